mem_stream_reader: RTL
======================

Name: mem_stream_reader

Overview:
- Read-side client for the team's 512x20 two-port memory (combinational read port `ra`/`q`, synchronous write port).
- On a start command, walks a contiguous address range from a base address and streams each 20-bit word out on a valid/ready interface.
- Sustains one word per cycle.
- Sits between the memory's read port and downstream consumers, e.g. a display or serializer.

Parameters:
- ADDR_W, 9, memory address width; depth = 2**ADDR_W.
- DATA_W, 20, memory word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base  input  ADDR_W  first address to read; sampled with start.
- len  input  ADDR_W+1  number of words; sampled with start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a command completes.
- ra  output  ADDR_W  read address to the memory.
- q  input  DATA_W  read data from the memory; combinational in ra, same cycle.
- out_data  output  DATA_W  streamed word, registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; busy, done, out_valid = 0; out_data = 0; ra = 0; all counters = 0. Reset mid-transfer abandons the transfer; no done pulse.
- Registers:
  - rd_addr: next address to fetch; drives ra directly.
  - fetch_cnt: words still to fetch.
  - send_cnt: words still to hand off.
- States:
  - IDLE -> RUN when start=1 and len!=0. On this edge: rd_addr<=base, fetch_cnt<=send_cnt<=min(len,2**ADDR_W).
  - IDLE, start=1, len=0: stay IDLE; done=1 on the next cycle; out_valid never asserts.
  - RUN -> IDLE on the edge that accepts the last word (send_cnt==1 and out_valid and out_ready). done=1 for exactly the following cycle.
- Load condition in RUN: load = fetch_cnt!=0 and (out_valid==0 or out_ready==1). On load: out_data<=q, out_valid<=1, rd_addr<=rd_addr+1, fetch_cnt<=fetch_cnt-1.
- Accept with no load (out_valid and out_ready, fetch_cnt==0): out_valid<=0.
- Every accept decrements send_cnt.
- Latency: start sampled at edge N. First word (mem[base]) is on out_data with out_valid=1 after edge N+2. With out_ready held high, word k appears after edge N+2+k.
- busy=1 from edge N+1 through the cycle of the last accept; busy=0 in the done cycle.
- Handshake:
  - out_valid, once high, stays high and out_data stays stable until accepted.
  - Transfer happens on any edge where out_valid and out_ready are both high.
  - out_ready may be high while out_valid is low; this has no effect.
- Address wrap: rd_addr increments modulo 2**ADDR_W, so base=510, len=4 reads 510, 511, 0, 1.
- len > 2**ADDR_W is clamped to 2**ADDR_W (each address read once).
- start while busy or during the done cycle: ignored, no queuing.
- Concurrent memory writes:
  - A word reflects memory contents at the cycle it is fetched (the load edge).
  - A write to an address not yet fetched is visible in the stream.
  - A word already in out_data is never altered by later writes.

Optional Feature:
- Macro MEM_STREAM_READER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), placed after len.
  - abort=1 in RUN: next edge goes to IDLE, out_valid<=0, counters cleared, done=1 the following cycle.
  - Any word pending on out_data is dropped.
  - If abort and the last accept occur on the same edge, the last accept completes normally; exactly one done pulse.
  - abort in IDLE is ignored.
- Not defined: no abort port; a transfer only ends by completion or rst.

Test Plan:
- Preload mem[i]=i+20'h100 for i=0..511; start, base=5, len=4, out_ready=1 -> out_valid first high 2 cycles after start; words 0x105, 0x106, 0x107, 0x108 on consecutive cycles; done pulses once; busy low afterwards.
- base=510, len=4, out_ready=1 -> words 0x2FE, 0x2FF, 0x100, 0x101 (address wrap).
- base=0, len=3, out_ready toggling 1,0,0,1,1 -> out_data holds 0x101 while ready=0; stream is exactly 0x100, 0x101, 0x102 with no repeats or drops.
- len=0 -> done pulse 1 cycle after start; out_valid stays 0. len=600 -> exactly 512 words, addresses base..base+511 mod 512.
- Mid-stream: write mem[9]=20'hABCDE while reading base=5, len=8 before address 9 is fetched -> stream contains 0xABCDE at position 4. A second start during busy is ignored.
- Assert rst during word 2 of a len=8 transfer -> next cycle busy=0, out_valid=0, done=0. With MEM_STREAM_READER_ABORT_EN: abort at the same point -> out_valid drops, one done pulse, a new start is accepted right after.

Source files
------------

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams base..base+len-1 of a 512x20 memory out on valid/ready.
// Ports: clk, rst, start/base/len command, [abort when MEM_STREAM_READER_ABORT_EN],
// busy, done, ra/q memory read port, out_data/out_valid/out_ready stream.
module mem_stream_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
`ifdef MEM_STREAM_READER_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   fetch_cnt;
  logic [ADDR_W:0]   send_cnt;
  logic [ADDR_W:0]   len_c;
  logic              load;
  logic              accept;
  logic              kill;

`ifdef MEM_STREAM_READER_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign ra     = rd_addr;
  assign len_c  = (len > DEPTH) ? DEPTH : len;
  assign accept = out_valid & out_ready;
  assign load   = (fetch_cnt != '0) & (~out_valid | out_ready);

  // ARM is a one-cycle gap after the command edge so that the first
  // word lands two edges after start and busy rises one edge after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      rd_addr   <= '0;
      fetch_cnt <= '0;
      send_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              rd_addr   <= base;
              fetch_cnt <= len_c;
              send_cnt  <= len_c;
              state     <= ARM;
            end
          end
        end
        ARM: begin
          if (kill) begin
            state     <= IDLE;
            fetch_cnt <= '0;
            send_cnt  <= '0;
            done      <= 1'b1;
          end else begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (kill) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            fetch_cnt <= '0;
            send_cnt  <= '0;
            done      <= 1'b1;
          end else begin
            if (load) begin
              out_data  <= q;
              out_valid <= 1'b1;
              rd_addr   <= rd_addr + 1'b1;
              fetch_cnt <= fetch_cnt - ONE;
            end else if (accept) begin
              out_valid <= 1'b0;
            end
            if (accept) begin
              send_cnt <= send_cnt - ONE;
              if (send_cnt == ONE) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
